// File: rtl/cpr_pkg.sv
// Shared widths, scheduler states and record types for the compress-unit scheduler.
package cpr_pkg;

  localparam int WORD_W      = 256;
  localparam int TAG_W       = 16;
  localparam int LEN_W       = 8;
  localparam int CNT_W       = 4;
  localparam int ISSUE_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } tap_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [LEN_W-1:0]  len;
  } cu_result_t;

endpackage

// File: rtl/cpr_id_pipe.sv
// LAT-deep {valid,id} delay line that tracks which requester owns each compress-unit slot.
module cpr_id_pipe
  import cpr_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id
);

  tap_t pipe_q [LAT];
  tap_t pipe_d [LAT];

  always_comb begin
    pipe_d[0] = '{valid: in_valid, id: in_id};
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: this array is reset on purpose; clearing it is what discards in-flight blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_valid = pipe_q[LAT-1].valid;
  assign out_id    = pipe_q[LAT-1].id;

endmodule

// File: rtl/cpr_unit_sched.sv
// Round-robin scheduler sharing one EightDataCompressUnit between two requesters,
// routing each result back by id and offering a flush/drain handshake.
module cpr_unit_sched
  import cpr_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [WORD_W-1:0]      req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [WORD_W-1:0]      req1_data,
  output logic                   req1_ready,
  output logic                   cu_wrtEn,
  output logic [WORD_W-1:0]      cu_dataIn,
  input  logic [WORD_W-1:0]      cu_dataOut,
  input  logic [TAG_W-1:0]       cu_tagOut,
  input  logic [LEN_W-1:0]       cu_lenOut,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [WORD_W-1:0]      rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [LEN_W-1:0]       rsp_len,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   busy,
  output logic [ISSUE_CNT_W-1:0] issue_cnt0,
  output logic [ISSUE_CNT_W-1:0] issue_cnt1
);

  sched_state_e           state_q, state_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_id_q, rsp_id_d;
  cu_result_t             rsp_res_q, rsp_res_d;
  logic                   flush_done_q, flush_done_d;
  logic [ISSUE_CNT_W-1:0] issue_cnt0_q, issue_cnt0_d;
  logic [ISSUE_CNT_W-1:0] issue_cnt1_q, issue_cnt1_d;

  logic grant_id;
  logic issue;
  logic tap_valid;
  logic tap_id;

  // Reset is folded in so no handshake can complete while reset is held.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_id = rr_ptr_q;
    end else begin
      grant_id = req1_valid;
    end
    issue = (state_q == RUN) && !flush_req && !reset && (req0_valid || req1_valid);
  end

  assign req0_ready = issue && !grant_id;
  assign req1_ready = issue && grant_id;
  assign cu_wrtEn   = issue;
  assign cu_dataIn  = issue ? (grant_id ? req1_data : req0_data) : '0;

  cpr_id_pipe #(
    .LAT (LAT)
  ) u_id_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue),
    .in_id     (grant_id),
    .out_valid (tap_valid),
    .out_id    (tap_id)
  );

  always_comb begin
    // NOTE: every variable here gets a default first so no path can infer a latch.
    rr_ptr_d     = rr_ptr_q;
    rsp_valid_d  = tap_valid;
    rsp_id_d     = rsp_id_q;
    rsp_res_d    = rsp_res_q;
    state_d      = state_q;
    issue_cnt0_d = issue_cnt0_q;
    issue_cnt1_d = issue_cnt1_q;

    if (issue) begin
      rr_ptr_d = !grant_id;
      if (grant_id) begin
        issue_cnt1_d = issue_cnt1_q + ISSUE_CNT_W'(1);
      end else begin
        issue_cnt0_d = issue_cnt0_q + ISSUE_CNT_W'(1);
      end
    end

    if (tap_valid) begin
      rsp_id_d  = tap_id;
      rsp_res_d = '{data: cu_dataOut, tag: cu_tagOut, len: cu_lenOut};
    end

    count_d = count_q + CNT_W'(issue) - CNT_W'(rsp_valid_q);

    // The retiring response already counts, so flush_done follows the last response directly.
    unique case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = DONE;
      DONE:    if (!flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase

    flush_done_d = (state_d == DONE);
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      rr_ptr_q     <= 1'b0;
      count_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      flush_done_q <= 1'b0;
      issue_cnt0_q <= '0;
      issue_cnt1_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_res_q    <= rsp_res_d;
      flush_done_q <= flush_done_d;
      issue_cnt0_q <= issue_cnt0_d;
      issue_cnt1_q <= issue_cnt1_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_res_q.data;
  assign rsp_tag    = rsp_res_q.tag;
  assign rsp_len    = rsp_res_q.len;
  assign flush_done = flush_done_q;
  assign busy       = (count_q != '0);
  assign issue_cnt0 = issue_cnt0_q;
  assign issue_cnt1 = issue_cnt1_q;

endmodule

// File: tb/tb_cpr_unit_sched.sv
// Two schedulers (LAT=1 and LAT=3) share one stimulus stream; each drives its own
// compress-unit stub, and a scoreboard checks every routed response.
module tb_cpr_unit_sched;

  typedef struct packed {
    logic [255:0] data;
    logic [15:0]  tag;
    logic [7:0]   len;
  } res_t;

  typedef struct {
    logic id;
    res_t res;
    int   due;
  } exp_t;

  localparam logic [255:0] DIR_VEC =
    256'hFEDC_BA98_0000_7654_0000_0032_1FED_CBA9_0000_8765_0000_0043_0000_0000_0000_0021;

  int lat_of [2] = '{1, 3};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, flush_req = 1'b0;
  logic [255:0] req0_data = '0, req1_data = '0;

  logic         rdy0 [2], rdy1 [2], wrt [2], rspv [2], rspid [2], fdone [2], busy [2];
  logic [255:0] din [2], rspd [2];
  logic [15:0]  rspt [2], ic0 [2], ic1 [2];
  logic [7:0]   rspl [2];

  res_t cu1_q;
  res_t cu3_q [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit           pend [2];
  logic [255:0] pdat [2];
  int           last_srv;
  int           mcnt [2];
  exp_t         exp_q [2][$];
  res_t         last_res [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic string nm(input int k, input string s);
    return $sformatf("L%0d %s", lat_of[k], s);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic res_t junk();
    res_t r;
    r.data = rand256();
    r.tag  = 16'($urandom);
    r.len  = 8'($urandom);
    return r;
  endfunction

  // Stand-in for the compression function: any deterministic mapping will do.
  function automatic res_t cu_model(input logic [255:0] d);
    res_t r;
    r.data = {d[127:0], d[255:128]} ^ {8{32'hA5C3_5A3C}};
    r.tag  = d[15:0] ^ d[143:128] ^ d[255:240];
    r.len  = 8'($countones(d));
    if (d == DIR_VEC) begin
      r.tag = 16'b1110011110010001;
      r.len = 8'h0F;
    end
    return r;
  endfunction

  // Compress-unit stubs: result of a wrtEn cycle appears LAT cycles later, junk otherwise.
  always @(posedge clk) begin
    cu1_q    <= wrt[0] ? cu_model(din[0]) : junk();
    cu3_q[0] <= wrt[1] ? cu_model(din[1]) : junk();
    cu3_q[1] <= cu3_q[0];
    cu3_q[2] <= cu3_q[1];
  end

  cpr_unit_sched #(.LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rdy0[0]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rdy1[0]),
    .cu_wrtEn(wrt[0]), .cu_dataIn(din[0]),
    .cu_dataOut(cu1_q.data), .cu_tagOut(cu1_q.tag), .cu_lenOut(cu1_q.len),
    .rsp_valid(rspv[0]), .rsp_id(rspid[0]), .rsp_data(rspd[0]), .rsp_tag(rspt[0]),
    .rsp_len(rspl[0]), .flush_req(flush_req), .flush_done(fdone[0]), .busy(busy[0]),
    .issue_cnt0(ic0[0]), .issue_cnt1(ic1[0])
  );

  cpr_unit_sched #(.LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rdy0[1]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rdy1[1]),
    .cu_wrtEn(wrt[1]), .cu_dataIn(din[1]),
    .cu_dataOut(cu3_q[2].data), .cu_tagOut(cu3_q[2].tag), .cu_lenOut(cu3_q[2].len),
    .rsp_valid(rspv[1]), .rsp_id(rspid[1]), .rsp_data(rspd[1]), .rsp_tag(rspt[1]),
    .rsp_len(rspl[1]), .flush_req(flush_req), .flush_done(fdone[1]), .busy(busy[1]),
    .issue_cnt0(ic0[1]), .issue_cnt1(ic1[1])
  );

  task automatic mon(input int k);
    exp_t e;
    if (rspv[k]) begin
      if (exp_q[k].size() == 0) begin
        n_checks++;
        $display("FAIL %s: got rsp_valid=1 id=%0d expected no response",
                 nm(k, "rsp_unexpected"), rspid[k]);
      end else begin
        e = exp_q[k].pop_front();
        check(nm(k, "rsp_cycle"), 256'(cyc), 256'(e.due));
        check(nm(k, "rsp_id"), 256'(rspid[k]), 256'(e.id));
        check(nm(k, "rsp_data"), rspd[k], e.res.data);
        check(nm(k, "rsp_tag"), 256'(rspt[k]), 256'(e.res.tag));
        check(nm(k, "rsp_len"), 256'(rspl[k]), 256'(e.res.len));
        last_res[k] = e.res;
      end
    end else begin
      check(nm(k, "hold_data"), rspd[k], last_res[k].data);
      check(nm(k, "hold_tag"), 256'(rspt[k]), 256'(last_res[k].tag));
      check(nm(k, "hold_len"), 256'(rspl[k]), 256'(last_res[k].len));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  task automatic clear_model();
    pend     = '{1'b0, 1'b0};
    last_srv = 1;
    mcnt     = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      last_res[k] = '0;
    end
  endtask

  task automatic refill(input int pct0, input int pct1);
    if (!pend[0] && $urandom_range(0, 99) < pct0) begin pend[0] = 1'b1; pdat[0] = rand256(); end
    if (!pend[1] && $urandom_range(0, 99) < pct1) begin pend[1] = 1'b1; pdat[1] = rand256(); end
  endtask

  // One cycle of stimulus; allow says whether the scheduler is expected to be in RUN.
  task automatic step(input bit fl, input bit allow);
    bit   go;
    int   w;
    exp_t e;
    @(negedge clk);
    req0_valid = pend[0];
    req0_data  = pdat[0];
    req1_valid = pend[1];
    req1_data  = pdat[1];
    flush_req  = fl;
    #1;
    go = allow && !fl && (pend[0] || pend[1]);
    if (pend[0] && pend[1]) w = 1 - last_srv;
    else w = pend[1] ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      check(nm(k, "req0_ready"), 256'(rdy0[k]), 256'(go && w == 0));
      check(nm(k, "req1_ready"), 256'(rdy1[k]), 256'(go && w == 1));
      check(nm(k, "cu_wrtEn"), 256'(wrt[k]), 256'(go));
      check(nm(k, "cu_dataIn"), din[k], go ? pdat[w] : 256'(0));
    end
    if (go) begin
      for (int k = 0; k < 2; k++) begin
        e.id  = (w == 1);
        e.res = cu_model(pdat[w]);
        e.due = cyc + lat_of[k] + 1;
        exp_q[k].push_back(e);
      end
      last_srv = w;
      mcnt[w]  = (mcnt[w] + 1) % 65536;
      pend[w]  = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    pend = '{1'b0, 1'b0};
    repeat (n) step(1'b0, 1'b1);
  endtask

  task automatic chk_cnt();
    for (int k = 0; k < 2; k++) begin
      check(nm(k, "issue_cnt0"), 256'(ic0[k]), 256'(mcnt[0]));
      check(nm(k, "issue_cnt1"), 256'(ic1[k]), 256'(mcnt[1]));
    end
  endtask

  task automatic chk_fd(input int k, input bit efd, input bit ebusy);
    check(nm(k, "flush_done"), 256'(fdone[k]), 256'(efd));
    check(nm(k, "busy"), 256'(busy[k]), 256'(ebusy));
  endtask

  task automatic chk_reset_vals();
    for (int k = 0; k < 2; k++) begin
      check(nm(k, "rst req0_ready"), 256'(rdy0[k]), 256'(0));
      check(nm(k, "rst req1_ready"), 256'(rdy1[k]), 256'(0));
      check(nm(k, "rst cu_wrtEn"), 256'(wrt[k]), 256'(0));
      check(nm(k, "rst cu_dataIn"), din[k], 256'(0));
      check(nm(k, "rst rsp_valid"), 256'(rspv[k]), 256'(0));
      check(nm(k, "rst rsp_id"), 256'(rspid[k]), 256'(0));
      check(nm(k, "rst rsp_data"), rspd[k], 256'(0));
      check(nm(k, "rst rsp_tag"), 256'(rspt[k]), 256'(0));
      check(nm(k, "rst rsp_len"), 256'(rspl[k]), 256'(0));
      check(nm(k, "rst flush_done"), 256'(fdone[k]), 256'(0));
      check(nm(k, "rst busy"), 256'(busy[k]), 256'(0));
      check(nm(k, "rst issue_cnt0"), 256'(ic0[k]), 256'(0));
      check(nm(k, "rst issue_cnt1"), 256'(ic1[k]), 256'(0));
    end
  endtask

  // Reset lands mid-cycle with both requesters valid, then outputs are checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b1;
    req0_data  = rand256();
    req1_valid = 1'b1;
    req1_data  = rand256();
    flush_req  = 1'b0;
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    int a;
    clear_model();
    do_reset();

    // Contention straight after reset: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      refill(100, 100);
      step(1'b0, 1'b1);
    end
    idle(6);
    chk_cnt();

    // Directed single issue from requester 0.
    pend[0] = 1'b1;
    pdat[0] = DIR_VEC;
    step(1'b0, 1'b1);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      refill(45, 45);
      step(1'b0, 1'b1);
    end
    idle(6);
    chk_cnt();

    // Flush with nothing in flight: DONE on the second edge, back to RUN after release.
    step(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) chk_fd(k, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) chk_fd(k, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) chk_fd(k, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int k = 0; k < 2; k++) chk_fd(k, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int k = 0; k < 2; k++) chk_fd(k, 1'b0, 1'b0);

    // Flush with one block in flight and requester 1 waiting.
    pend[0] = 1'b1;
    pdat[0] = rand256();
    step(1'b0, 1'b1);
    a = cyc;
    pend[1] = 1'b1;
    pdat[1] = rand256();
    for (int j = 1; j <= 8; j++) begin
      step(1'b1, 1'b0);
      for (int k = 0; k < 2; k++)
        chk_fd(k, (cyc - a) >= lat_of[k] + 2, (cyc - a) <= lat_of[k] + 1);
    end
    step(1'b0, 1'b0);
    for (int k = 0; k < 2; k++) chk_fd(k, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(6);
    chk_cnt();

    // Reset one cycle after an issue: the in-flight block must never respond.
    pend[0] = 1'b1;
    pdat[0] = rand256();
    step(1'b0, 1'b1);
    do_reset();
    idle(12);
    chk_cnt();

    // Counter wrap on requester 0.
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      refill(100, 0);
      step(1'b0, 1'b1);
    end
    idle(1);
    chk_cnt();
    refill(100, 0);
    step(1'b0, 1'b1);
    idle(6);
    chk_cnt();
    for (int k = 0; k < 2; k++) check(nm(k, "final issue_cnt0"), 256'(ic0[k]), 256'(0));

    for (int k = 0; k < 2; k++)
      check(nm(k, "queue_empty"), 256'(exp_q[k].size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpr_unit_sched.md
CPR_UNIT_SCHED -- requirements
Module: cpr_unit_sched

Interface
REQ-001 SHALL have parameter LAT, default 1: registered latency of the shared EightDataCompressUnit, from the wrtEn cycle to its output cycle; legal range 1..8.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each: requester has a 256-bit block pending.
REQ-005 SHALL have ports req0_data / req1_data, input, 256 each: eight 32-bit words per block.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each: block accepted this cycle.
REQ-007 SHALL have port cu_wrtEn, output, 1: write enable to the compress unit.
REQ-008 SHALL have port cu_dataIn, output, 256: data to the compress unit.
REQ-009 SHALL have ports cu_dataOut (input, 256), cu_tagOut (input, 16), cu_lenOut (input, 8): compress unit results.
REQ-010 SHALL have ports rsp_valid (output, 1), rsp_id (output, 1), rsp_data (output, 256), rsp_tag (output, 16), rsp_len (output, 8): routed result.
REQ-011 SHALL have ports flush_req (input, 1) and flush_done (output, 1): drain handshake.
REQ-012 SHALL have port busy, output, 1: one or more blocks in flight.
REQ-013 SHALL have ports issue_cnt0 / issue_cnt1, output, 16 each: accepted-block counters.

Function
REQ-014 SHALL drive req0_ready and req1_ready combinationally:
- ready = (state==RUN) & !flush_req & granted.
- At most one ready per cycle.
REQ-015 SHALL arbitrate round-robin:
- A single valid requester wins.
- When both are valid, the requester indicated by rr_ptr wins.
- rr_ptr becomes the other requester after each issue and holds when nothing is issued.
REQ-016 SHALL set cu_wrtEn=1 and cu_dataIn=granted data in the issue cycle; cu_dataIn SHALL be 0 whenever cu_wrtEn=0.
REQ-017 SHALL carry {valid,id} for each issue through a LAT-deep delay line. When the tap is valid, it SHALL register cu_dataOut/cu_tagOut/cu_lenOut into rsp_data/rsp_tag/rsp_len with rsp_valid=1 and rsp_id=id. Issue-to-rsp_valid latency is LAT+1 cycles.
REQ-018 SHALL hold rsp_data/tag/len when rsp_valid=0. rsp_valid SHALL be a one-cycle pulse per block and SHALL NOT be subject to backpressure.
REQ-019 SHALL keep a 4-bit in-flight count, +1 on issue and -1 on rsp_valid (net 0 if both occur in the same cycle). busy = (count != 0).
REQ-020 SHALL implement FSM states RUN, DRAIN, DONE:
- RUN -> DRAIN when flush_req=1.
- DRAIN -> DONE when count==0.
- DONE -> RUN when flush_req=0.
REQ-021 SHALL assert flush_done=1 only in DONE. A flush with nothing in flight SHALL reach DONE on the second edge after flush_req rises.
REQ-022 SHALL give flush_req priority over a same-cycle valid: no issue occurs and the requester's valid stays pending.
REQ-023 SHALL issue nothing in DRAIN or DONE, and SHALL still deliver every in-flight result.
REQ-024 SHALL increment issue_cntN on each issue for requester N, wrapping 16'hFFFF -> 16'h0000.
REQ-025 SHALL permit back-to-back issue every cycle, bounded only by arbitration.

Reset
REQ-026 SHALL, on reset assertion, set the following immediately and asynchronously:
- state=RUN, rr_ptr=0, delay line cleared, count=0.
- rsp_valid=0, rsp_id=0, rsp_data/tag/len=0, flush_done=0, issue_cnt0/1=0.
REQ-027 SHALL discard in-flight blocks when reset is asserted mid-operation; no rsp_valid SHALL occur for them after release.
REQ-028 SHALL force req0_ready, req1_ready and cu_wrtEn to 0 while reset=1.

Structure
REQ-029 SHALL take WORD_W=256, TAG_W=16, LEN_W=8 and the RUN/DRAIN/DONE state encoding from shared package cpr_pkg.
REQ-030 SHALL place the {valid,id} delay line in sub-module cpr_id_pipe (parameter LAT, ports clk, reset).

Verification
REQ-031 SHALL cover single issue: LAT=1, req0_valid=1, req0_data=256'hFEDC_BA98_0000_7654_0000_0032_1FED_CBA9_0000_8765_0000_0043_0000_0000_0000_0021 at cycle t -> required response:
- req0_ready=1 and cu_wrtEn=1 at t.
- rsp_valid=1, rsp_id=0 at t+2, with rsp_tag=16'b1110011110010001 and rsp_len=8'h0F when the model returns those values.
REQ-032 SHALL cover contention: both valid for 4 cycles after reset -> grants 0,1,0,1; rsp_id sequence 0,1,0,1; issue_cnt0=2, issue_cnt1=2.
REQ-033 SHALL cover flush with traffic: flush_req raised while one block is in flight and req1_valid=1 -> req1_ready=0; rsp_valid for the in-flight block; flush_done=1 the following cycle; req1 issues only after flush_req=0.
REQ-034 SHALL cover reset mid-flight: reset asserted one cycle after an issue with LAT=3 -> every output at its reset value; no rsp_valid within 10 cycles after release.
REQ-035 SHALL cover counter wrap: 65536 issues from requester 0 -> issue_cnt0 = 16'h0000, issue_cnt1 = 16'h0000.
